// File: rtl/key_lut_pkg.sv
// key_lut_pkg: shared types and helpers for the key lookup table.
// Default widths describe the standard {vld, key, data} entry record.
package key_lut_pkg;

  localparam int KEY_LEN_DEF  = 2;
  localparam int DATA_LEN_DEF = 2;

  typedef struct packed {
    logic                    vld;
    logic [KEY_LEN_DEF-1:0]  key;
    logic [DATA_LEN_DEF-1:0] data;
  } entry_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_lut_match.sv
// key_lut_match: combinational table search, lowest index wins.
// Reusable priority matcher for CAM-style blocks.
module key_lut_match
  import key_lut_pkg::*;
#(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2,
  localparam int IDX_W   = idx_w(NR_KEY)
) (
  input  logic [NR_KEY-1:0]                vld,
  input  logic [NR_KEY-1:0][KEY_LEN-1:0]   keys,
  input  logic [NR_KEY-1:0][DATA_LEN-1:0]  datas,
  input  logic [KEY_LEN-1:0]               key,
  output logic                             hit,
  output logic [IDX_W-1:0]                 idx,
  output logic [DATA_LEN-1:0]              data
);

  // Scan high to low so the lowest matching index is assigned last.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    data = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (vld[i] && (keys[i] == key)) begin
        hit  = 1'b1;
        idx  = IDX_W'(i);
        data = datas[i];
      end
    end
  end

endmodule

// File: rtl/key_lut_mux.sv
// key_lut_mux: programmable key->data table with a registered
// valid/ready lookup stage and a programmable miss default.
module key_lut_mux
  import key_lut_pkg::*;
#(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2,
  localparam int IDX_W   = idx_w(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                wr_vld,
  input  logic                def_en,
  input  logic [DATA_LEN-1:0] def_data,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_LEN-1:0]  in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_hit,
  output logic [IDX_W-1:0]    out_idx
);

  logic [NR_KEY-1:0]               vld_q, vld_d;
  logic [NR_KEY-1:0][KEY_LEN-1:0]  key_q, key_d;
  logic [NR_KEY-1:0][DATA_LEN-1:0] data_q, data_d;
  logic [DATA_LEN-1:0]             def_q, def_d;

  logic                ov_q, ov_d;
  logic [DATA_LEN-1:0] od_q, od_d;
  logic                oh_q, oh_d;
  logic [IDX_W-1:0]    oi_q, oi_d;

  logic                m_hit;
  logic [IDX_W-1:0]    m_idx;
  logic [DATA_LEN-1:0] m_data;
  logic                accept;

  key_lut_match #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_match (
    .vld   (vld_q),
    .keys  (key_q),
    .datas (data_q),
    .key   (in_key),
    .hit   (m_hit),
    .idx   (m_idx),
    .data  (m_data)
  );

  assign in_ready = !ov_q || out_ready;
  assign accept   = in_valid && in_ready;

  // clr first, then the write, so a same-cycle write survives.
  always_comb begin
    vld_d  = vld_q;
    key_d  = key_q;
    data_d = data_q;
    def_d  = def_q;
    if (clr) vld_d = '0;
    if (wr_en && (int'(wr_idx) < NR_KEY)) begin
      vld_d[wr_idx]  = wr_vld;
      key_d[wr_idx]  = wr_key;
      data_d[wr_idx] = wr_data;
    end
    if (def_en) def_d = def_data;
  end

  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    oh_d = oh_q;
    oi_d = oi_q;
    if (accept) begin
      ov_d = 1'b1;
      oh_d = m_hit;
      oi_d = m_idx;
      od_d = m_hit ? m_data : def_q;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      key_q  <= '0;
      data_q <= '0;
      def_q  <= '0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      oh_q   <= 1'b0;
      oi_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      key_q  <= key_d;
      data_q <= data_d;
      def_q  <= def_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      oh_q   <= oh_d;
      oi_q   <= oi_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_hit   = oh_q;
  assign out_idx   = oi_q;

endmodule

// File: doc/key_lut_mux.md
# key_lut_mux

Programmable, registered key-to-data lookup mux. It is the table-driven successor to the combinational key mux: the key/data pairs live in writable registers instead of being fixed at elaboration. Lookups pass through a one-stage valid/ready pipeline with priority hit resolution and a programmable miss default. It sits between a decode front-end and any consumer that needs runtime-configurable key selection, such as a remap table or opcode dispatch.

## Interface
- NR_KEY, 4, number of table entries (≥2)
- KEY_LEN, 2, key width in bits (≥1)
- DATA_LEN, 2, data width in bits (≥1)
- IDX_W, $clog2(NR_KEY), entry index width (derived, not overridden)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write one table entry this cycle
- wr_idx  in  IDX_W  entry to write
- wr_key  in  KEY_LEN  key stored in entry
- wr_data  in  DATA_LEN  data stored in entry
- wr_vld  in  1  entry-valid bit stored (0 = invalidate)
- def_en  in  1  load default register
- def_data  in  DATA_LEN  new miss default
- clr  in  1  invalidate all entries (default register unchanged)
- in_valid  in  1  lookup request valid
- in_ready  out  1  lookup accepted when in_valid & in_ready
- in_key  in  KEY_LEN  lookup key
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_LEN  hit data or default
- out_hit  out  1  1 = key matched a valid entry
- out_idx  out  IDX_W  matching entry index (0 on miss)

## Operation
- Table: NR_KEY entries of {vld, key, data}. Default register: DATA_LEN.
- Match: an entry is a candidate when vld=1 and key==in_key. The lowest-index candidate wins, so duplicate keys are legal and resolve deterministically. This differs from OR-combining all matches.
- Miss: out_data=default register, out_hit=0, out_idx=0.
- in_ready = !out_valid | out_ready (single-entry pipeline, full throughput).
- Accept: at the edge with in_valid & in_ready, the match result is registered into out_* and out_valid is set to 1.
- Drain: at the edge with out_valid & out_ready & !accept, out_valid clears.
- Stall: while out_valid & !out_ready, out_data, out_hit and out_idx are held stable.
- Write: wr_en updates entry wr_idx at the edge. If wr_idx ≥ NR_KEY (non-power-of-2 NR_KEY), the write is ignored.
- clr: all vld bits clear at the edge. If clr and wr_en occur together, clr is applied first and the write lands, so only wr_idx can be valid afterwards.
- def_en updates the default register at the edge.
- Read-during-write: a lookup accepted in the same cycle as wr_en, clr or def_en sees the pre-edge table and default. Updates become visible to lookups from the next cycle.
- An already-registered result is never altered by later table writes.

## Timing
- Lookup latency is 1 cycle: a request accepted at edge N produces out_valid high after edge N.
- Throughput is 1 lookup/cycle while out_ready=1.
- Reset (async assert, sync-safe deassert handled externally):
  - all vld=0, keys=0, data=0, default=0
  - out_valid=0, out_data=0, out_hit=0, out_idx=0
- Reset mid-operation drops any pending result. in_ready=1 during and after reset.
- in_ready has a combinational path from out_ready only. There is no path from in_key to any output.

## Structure
- Shared package key_lut_pkg holds:
  - typedef of the entry record {vld, key, data}, parameterised via macros or localparam widths
  - IDX_W computation function
- Sub-module key_lut_match (combinational): table + key → {hit, idx, data} with lowest-index priority. It is the only logic reused by future CAM-style blocks.
- The top holds table registers, default register, output pipeline register and handshake.

## Test plan
- Reset then lookup key 2'b01 with empty table → out_hit=0, out_data=0, one cycle later.
- Write idx0={1,2'b10,2'b11}, def=2'b01; lookup 2'b10 → hit=1, idx=0, data=2'b11; lookup 2'b00 → hit=0, data=2'b01.
- Duplicate key 2'b11 in idx1 (data 2'b01) and idx3 (data 2'b10) → data=2'b01, idx=1.
- Hold out_ready=0 three cycles with new in_valid → in_ready=0, outputs stable. Release → back-to-back results one per cycle, none lost or duplicated.
- Same cycle: write idx2 key 2'b00 and lookup 2'b00 → miss. Next-cycle lookup → hit idx2. Same cycle clr+write idx1 → only idx1 valid.
- Assert rst_n=0 while out_valid=1 and stalled → out_valid=0 immediately. Table is empty after release.
